candy_vend_ctrl: RTL and testbench
==================================

Name: candy_vend_ctrl

Overview:
Vending-machine control stage that feeds the 7-segment column selector. Accepts coin and button pulses and tracks the inserted credit. Dispenses candy at a fixed price and returns change on refund. Drives the running credit `sum[3:0]` and the dispensed-candy count `candy_sum[2:0]` consumed by the display multiplexer.

Parameters:
PRICE, 5, candy cost in credit units; legal range 1..15
STOCK, 7, candies loaded; legal range 1..7; `candy_sum` never exceeds it
DISPENSE_CYCLES, 4, number of cycles `dispense` is held high per vend; legal range 1..15

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-low reset
coin_valid  in  1  coin inserted; one-cycle pulse unless COIN_EDGE_DETECT_EN
coin_val  in  2  coin value code: 00=1, 01=2, 10=5, 11=10
buy  in  1  purchase request pulse
refund  in  1  refund request pulse
sum  out  4  current credit, to display stage
candy_sum  out  3  candies dispensed since reset, to display stage
dispense  out  1  candy motor drive
change_out  out  4  change amount; valid only while change_valid=1
change_valid  out  1  one-cycle change strobe
coin_reject  out  1  one-cycle pulse: coin not accepted
buy_denied  out  1  one-cycle pulse: buy refused
sold_out  out  1  level: candy_sum == STOCK

Behaviour:
- Reset (reset=0 at a clock edge), regardless of state:
  - state=IDLE.
  - sum=0, candy_sum=0, change_out=0.
  - dispense, change_valid, coin_reject, buy_denied all 0.
  - Dispense counter=0.
  - Reset mid-vend aborts the vend immediately; no change is returned.
- States:
  - IDLE: sum==0.
  - CREDIT: sum>0.
  - VEND: dispensing.
  - CHANGE: single cycle, returning change.
- Request priority in IDLE/CREDIT when several inputs are high in the same cycle: buy > refund > coin. A coin arriving alongside an accepted or denied buy or refund is rejected (coin_reject=1).
- Coin (IDLE/CREDIT, no buy/refund):
  - Compute sum + value in 5-bit arithmetic.
  - If the result is ≤15: sum updates next cycle; state becomes CREDIT.
  - Else: coin_reject=1 next cycle; sum unchanged (no wrap).
- Buy accepted at edge N when sum ≥ PRICE and candy_sum < STOCK:
  - From N+1: sum = sum − PRICE, candy_sum += 1, dispense=1, state=VEND.
  - dispense stays high exactly DISPENSE_CYCLES cycles (N+1 .. N+DISPENSE_CYCLES).
  - On the edge ending the last dispense cycle: state → CREDIT if sum>0, else IDLE.
- Buy refused (sum < PRICE, or sold out): buy_denied=1 for one cycle at N+1; state and sum unchanged.
- Refund at edge N:
  - If sum>0: at N+1 state=CHANGE, change_out=old sum, change_valid=1, sum=0.
  - At N+2: state=IDLE, change_valid=0, change_out=0.
  - Refund with sum==0 is ignored (no strobe).
- VEND and CHANGE ignore buy and refund. Coins arriving in VEND or CHANGE are rejected with coin_reject next cycle.
- candy_sum saturates at STOCK; sold_out is combinational from candy_sum.
- All outputs are registered except sold_out.

Optional Feature:
COIN_EDGE_DETECT_EN:
- Defined: coin_valid, buy and refund each pass through a one-flop rising-edge detector, reset to 0. A level held for many cycles counts once. Acceptance latency grows by one cycle (the edge is seen at N, the effect at N+1 after the detector flop, i.e. response at N+2 relative to the input rise).
- Undefined: inputs are treated as pre-conditioned one-cycle pulses. A level held k cycles counts k times.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release -> sum=0, candy_sum=0, all strobes 0, sold_out=0.
- Coin sequence 5,2,1 (codes 10,01,00) -> sum 5, 7, 8. Then coin 10 -> coin_reject pulse, sum stays 8.
- sum=8, buy -> dispense high exactly 4 cycles; sum=3 and candy_sum=1 from the first dispense cycle; state returns to CREDIT. A coin during dispense -> coin_reject, sum stays 3.
- sum=3, buy -> buy_denied one cycle, sum 3. Then refund -> change_out=3 with change_valid for one cycle, sum=0, state IDLE.
- Same cycle buy+refund+coin with sum=10 -> vend occurs, refund ignored, coin_reject=1, sum=5.
- Seven vends with 5 credit each -> candy_sum=7, sold_out=1; next buy with sum=5 -> buy_denied, sum stays 5.

Source files
------------

// File: rtl/candy_vend_ctrl.sv
// Vending controller: coin credit, fixed-price vend with timed motor drive, refund strobe.
// Optional macro COIN_EDGE_DETECT_EN adds rising-edge detectors on coin_valid, buy and refund.
module candy_vend_ctrl #(
  parameter int unsigned PRICE           = 5,
  parameter int unsigned STOCK           = 7,
  parameter int unsigned DISPENSE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_val,
  input  logic       buy,
  input  logic       refund,
  output logic [3:0] sum,
  output logic [2:0] candy_sum,
  output logic       dispense,
  output logic [3:0] change_out,
  output logic       change_valid,
  output logic       coin_reject,
  output logic       buy_denied,
  output logic       sold_out
);

  // state  | meaning
  // IDLE   | no credit held
  // CREDIT | credit held, waiting for coin/buy/refund
  // VEND   | motor driven for DISPENSE_CYCLES cycles
  // CHANGE | one cycle, change strobe asserted
  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  localparam logic [4:0] PRICE_L  = 5'(PRICE);
  localparam logic [2:0] STOCK_L  = 3'(STOCK);
  localparam logic [3:0] CNT_LAST = 4'(DISPENSE_CYCLES - 1);

  state_t     state_q, state_n;
  logic [3:0] sum_n, change_out_n, cnt_q, cnt_n;
  logic [2:0] candy_n;
  logic       dispense_n, change_valid_n, coin_reject_n, buy_denied_n;
  logic       coin_p, buy_p, refund_p;
  logic [1:0] val_p;
  logic [4:0] coin_amt, coin_total;

`ifdef COIN_EDGE_DETECT_EN
  logic coin_d, buy_d, refund_d;
  always_ff @(posedge clk) begin
    if (!reset) begin
      coin_d   <= 1'b0;
      buy_d    <= 1'b0;
      refund_d <= 1'b0;
      coin_p   <= 1'b0;
      buy_p    <= 1'b0;
      refund_p <= 1'b0;
      val_p    <= 2'b00;
    end else begin
      coin_d   <= coin_valid;
      buy_d    <= buy;
      refund_d <= refund;
      coin_p   <= coin_valid & ~coin_d;
      buy_p    <= buy & ~buy_d;
      refund_p <= refund & ~refund_d;
      val_p    <= coin_val;
    end
  end
`else
  assign coin_p   = coin_valid;
  assign buy_p    = buy;
  assign refund_p = refund;
  assign val_p    = coin_val;
`endif

  always_comb begin
    case (val_p)
      2'b00:   coin_amt = 5'd1;
      2'b01:   coin_amt = 5'd2;
      2'b10:   coin_amt = 5'd5;
      default: coin_amt = 5'd10;
    endcase
  end

  assign coin_total = {1'b0, sum} + coin_amt;

  always_comb begin
    state_n        = state_q;
    sum_n          = sum;
    candy_n        = candy_sum;
    cnt_n          = cnt_q;
    dispense_n     = 1'b0;
    change_out_n   = 4'd0;
    change_valid_n = 1'b0;
    coin_reject_n  = 1'b0;
    buy_denied_n   = 1'b0;
    case (state_q)
      IDLE, CREDIT: begin
        if (buy_p) begin
          coin_reject_n = coin_p;
          if (({1'b0, sum} >= PRICE_L) && (candy_sum < STOCK_L)) begin
            state_n    = VEND;
            sum_n      = 4'(({1'b0, sum} - PRICE_L));
            candy_n    = candy_sum + 3'd1;
            cnt_n      = CNT_LAST;
            dispense_n = 1'b1;
          end else begin
            buy_denied_n = 1'b1;
          end
        end else if (refund_p) begin
          coin_reject_n = coin_p;
          if (sum != 4'd0) begin
            state_n        = CHANGE;
            change_out_n   = sum;
            change_valid_n = 1'b1;
            sum_n          = 4'd0;
          end
        end else if (coin_p) begin
          if (coin_total <= 5'd15) begin
            sum_n   = coin_total[3:0];
            state_n = CREDIT;
          end else begin
            coin_reject_n = 1'b1;
          end
        end
      end
      VEND: begin
        coin_reject_n = coin_p;
        if (cnt_q == 4'd0) begin
          state_n = (sum != 4'd0) ? CREDIT : IDLE;
        end else begin
          cnt_n      = cnt_q - 4'd1;
          dispense_n = 1'b1;
        end
      end
      CHANGE: begin
        coin_reject_n = coin_p;
        state_n       = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      sum          <= 4'd0;
      candy_sum    <= 3'd0;
      cnt_q        <= 4'd0;
      dispense     <= 1'b0;
      change_out   <= 4'd0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      buy_denied   <= 1'b0;
    end else begin
      state_q      <= state_n;
      sum          <= sum_n;
      candy_sum    <= candy_n;
      cnt_q        <= cnt_n;
      dispense     <= dispense_n;
      change_out   <= change_out_n;
      change_valid <= change_valid_n;
      coin_reject  <= coin_reject_n;
      buy_denied   <= buy_denied_n;
    end
  end

  assign sold_out = (candy_sum == STOCK_L);

endmodule

// File: tb/tb_candy_vend_ctrl.sv
// Directed bench for candy_vend_ctrl (default build): expected outputs are queued per step
// and compared one clock later.
module tb_candy_vend_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid, buy, refund;
  logic [1:0] coin_val;
  logic [3:0] sum, change_out;
  logic [2:0] candy_sum;
  logic       dispense, change_valid, coin_reject, buy_denied, sold_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] sum;
    logic [2:0] candy;
    logic       disp;
    logic       chg_v;
    logic [3:0] chg_o;
    logic       rej;
    logic       den;
    logic       sold;
  } exp_t;

  exp_t sb[$];

  candy_vend_ctrl dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_val(coin_val),
    .buy(buy), .refund(refund), .sum(sum), .candy_sum(candy_sum),
    .dispense(dispense), .change_out(change_out), .change_valid(change_valid),
    .coin_reject(coin_reject), .buy_denied(buy_denied), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue what the outputs must be after the edge, then compare.
  task automatic cyc(input logic cv, input logic [1:0] val, input logic b, input logic r,
                     input exp_t e);
    exp_t got;
    coin_valid = cv;
    coin_val   = val;
    buy        = b;
    refund     = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    coin_valid = 1'b0;
    buy        = 1'b0;
    refund     = 1'b0;
    got = sb.pop_front();
    chk("sum",          sum,                  got.sum);
    chk("candy_sum",    {1'b0, candy_sum},    {1'b0, got.candy});
    chk("dispense",     {3'b0, dispense},     {3'b0, got.disp});
    chk("change_valid", {3'b0, change_valid}, {3'b0, got.chg_v});
    chk("change_out",   change_out,           got.chg_o);
    chk("coin_reject",  {3'b0, coin_reject},  {3'b0, got.rej});
    chk("buy_denied",   {3'b0, buy_denied},   {3'b0, got.den});
    chk("sold_out",     {3'b0, sold_out},     {3'b0, got.sold});
  endtask

  function automatic exp_t mk(input logic [3:0] s, input logic [2:0] c, input logic d,
                              input logic cv, input logic [3:0] co, input logic rj,
                              input logic dn, input logic so);
    exp_t e;
    e.sum = s; e.candy = c; e.disp = d; e.chg_v = cv;
    e.chg_o = co; e.rej = rj; e.den = dn; e.sold = so;
    return e;
  endfunction

  initial begin
    reset      = 1'b0;
    coin_valid = 1'b0;
    coin_val   = 2'b00;
    buy        = 1'b0;
    refund     = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, 2'b00, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;

    // coins 5, 2, 1 then an overflowing 10
    cyc(1, 2'b10, 0, 0, mk(5, 0, 0, 0, 0, 0, 0, 0));
    cyc(1, 2'b01, 0, 0, mk(7, 0, 0, 0, 0, 0, 0, 0));
    cyc(1, 2'b00, 0, 0, mk(8, 0, 0, 0, 0, 0, 0, 0));
    cyc(1, 2'b11, 0, 0, mk(8, 0, 0, 0, 0, 1, 0, 0));

    // vend from 8: four dispense cycles, coin rejected mid-vend
    cyc(0, 2'b00, 1, 0, mk(3, 1, 1, 0, 0, 0, 0, 0));
    cyc(1, 2'b00, 0, 0, mk(3, 1, 1, 0, 0, 1, 0, 0));
    cyc(0, 2'b00, 0, 0, mk(3, 1, 1, 0, 0, 0, 0, 0));
    cyc(0, 2'b00, 0, 0, mk(3, 1, 1, 0, 0, 0, 0, 0));
    cyc(0, 2'b00, 0, 0, mk(3, 1, 0, 0, 0, 0, 0, 0));

    // insufficient credit, then refund of 3, then refund with no credit
    cyc(0, 2'b00, 1, 0, mk(3, 1, 0, 0, 0, 0, 1, 0));
    cyc(0, 2'b00, 0, 1, mk(0, 1, 0, 1, 3, 0, 0, 0));
    cyc(0, 2'b00, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0));
    cyc(0, 2'b00, 0, 1, mk(0, 1, 0, 0, 0, 0, 0, 0));

    // sum=10, simultaneous buy+refund+coin: buy wins, coin rejected
    cyc(1, 2'b10, 0, 0, mk(5, 1, 0, 0, 0, 0, 0, 0));
    cyc(1, 2'b10, 0, 0, mk(10, 1, 0, 0, 0, 0, 0, 0));
    cyc(1, 2'b00, 1, 1, mk(5, 2, 1, 0, 0, 1, 0, 0));
    cyc(0, 2'b00, 0, 0, mk(5, 2, 1, 0, 0, 0, 0, 0));
    cyc(0, 2'b00, 0, 0, mk(5, 2, 1, 0, 0, 0, 0, 0));
    cyc(0, 2'b00, 0, 0, mk(5, 2, 1, 0, 0, 0, 0, 0));
    cyc(0, 2'b00, 0, 0, mk(5, 2, 0, 0, 0, 0, 0, 0));

    // five more vends at 5 credit each until sold out
    for (int i = 0; i < 5; i++) begin
      logic [2:0] c;
      logic       so;
      c  = 3'(3 + i);
      so = (i == 4);
      cyc(0, 2'b00, 1, 0, mk(0, c, 1, 0, 0, 0, 0, so));
      cyc(0, 2'b00, 0, 0, mk(0, c, 1, 0, 0, 0, 0, so));
      cyc(0, 2'b00, 0, 0, mk(0, c, 1, 0, 0, 0, 0, so));
      cyc(0, 2'b00, 0, 0, mk(0, c, 1, 0, 0, 0, 0, so));
      cyc(0, 2'b00, 0, 0, mk(0, c, 0, 0, 0, 0, 0, so));
      cyc(1, 2'b10, 0, 0, mk(5, c, 0, 0, 0, 0, 0, so));
    end

    // sold out: buy refused, credit kept
    cyc(0, 2'b00, 1, 0, mk(5, 7, 0, 0, 0, 0, 1, 1));
    cyc(0, 2'b00, 0, 0, mk(5, 7, 0, 0, 0, 0, 0, 1));

    // synchronous reset clears everything
    reset = 1'b0;
    cyc(0, 2'b00, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
